player_position_ctrl: RTL

//  Owns the player's grid position and drives the combinational collision stage.

---
 rtl/game_pkg.sv | 38 +++
 rtl/btn_sync_edge.sv | 25 ++
 rtl/player_position_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// game_pkg -- shared definitions for the grid game blocks.
//   Move codes presented to the collision stage, grid size, the position
//   controller state encoding and the button index / priority helper.
package game_pkg;

    localparam logic [2:0] MOVE_NONE  = 3'b000;
    localparam logic [2:0] MOVE_UP    = 3'b001;
    localparam logic [2:0] MOVE_LEFT  = 3'b010;
    localparam logic [2:0] MOVE_DOWN  = 3'b011;
    localparam logic [2:0] MOVE_RIGHT = 3'b100;

    localparam int GRID_W = 20;
    localparam int GRID_H = 15;

    // Bit positions inside the packed button vector.
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int NUM_BTN   = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETTLE   = 2'd1,
        ST_LATCH    = 2'd2,
        ST_COOLDOWN = 2'd3
    } state_t;

    // Highest-priority request wins: UP > DOWN > LEFT > RIGHT.
    function automatic logic [2:0] btn_to_move(input logic [NUM_BTN-1:0] req);
        if (req[BTN_UP])    return MOVE_UP;
        if (req[BTN_DOWN])  return MOVE_DOWN;
        if (req[BTN_LEFT])  return MOVE_LEFT;
        if (req[BTN_RIGHT]) return MOVE_RIGHT;
        return MOVE_NONE;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// btn_sync_edge -- 2-FF synchronizer plus rising-edge detect for one button.
//   clk, reset : system clock, asynchronous active-high reset
//   btn_i      : raw button level, asynchronous to clk
//   lvl_o      : synchronized level
//   rise_o     : one-cycle pulse on a 0->1 transition of lvl_o
module btn_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic lvl_o,
    output logic rise_o
);

    // [0],[1] form the synchronizer; [2] is the previous synchronized level.
    logic [2:0] sh_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sh_q <= '0;
        else       sh_q <= {sh_q[1:0], btn_i};
    end

    assign lvl_o  = sh_q[1];
    assign rise_o = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/player_position_ctrl.sv
// player_position_ctrl -- owns the player grid position.
//   Turns button edges into one move at a time: presents the move code to the
//   collision stage, lets its answer settle, registers it as the new position,
//   then holds off further requests for a cooldown period.
// Ports:
//   clk, reset          : system clock, asynchronous active-high reset
//   btn_up/down/left/right : raw direction buttons (asynchronous)
//   map_load            : 1-cycle pulse, return to start position
//   new_x_in, new_y_in  : collision stage resolved position
//   move_out            : move code to collision stage
//   cur_x, cur_y        : registered position
//   moved, blocked      : 1-cycle result pulses
//   busy                : FSM not in IDLE
// Optional feature: define PLAYER_REPEAT_EN for hold-to-repeat.
module player_position_ctrl
    import game_pkg::*;
#(
    parameter logic [4:0]  START_X        = 5'd1,
    parameter logic [4:0]  START_Y        = 5'd1,
    parameter int unsigned SETTLE_CYCLES  = 2,
    parameter int unsigned COOLDOWN_TICKS = 5000000,
    parameter int unsigned REPEAT_TICKS   = 10000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       map_load,
    input  logic [4:0] new_x_in,
    input  logic [4:0] new_y_in,
    output logic [2:0] move_out,
    output logic [4:0] cur_x,
    output logic [4:0] cur_y,
    output logic       moved,
    output logic       blocked,
    output logic       busy
);

    localparam int unsigned CNT_MAX_SC =
        (SETTLE_CYCLES > COOLDOWN_TICKS) ? SETTLE_CYCLES : COOLDOWN_TICKS;
    localparam int unsigned CNT_MAX =
        (CNT_MAX_SC > REPEAT_TICKS) ? CNT_MAX_SC : REPEAT_TICKS;
    localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] COOL_LD   = CW'(COOLDOWN_TICKS - 1);

    // ---- button front end ------------------------------------------------
    logic [NUM_BTN-1:0] btn_raw, btn_lvl, btn_rise;

    assign btn_raw[BTN_UP]    = btn_up;
    assign btn_raw[BTN_DOWN]  = btn_down;
    assign btn_raw[BTN_LEFT]  = btn_left;
    assign btn_raw[BTN_RIGHT] = btn_right;

    btn_sync_edge u_sync [NUM_BTN-1:0] (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (btn_raw),
        .lvl_o  (btn_lvl),
        .rise_o (btn_rise)
    );

    // ---- state -----------------------------------------------------------
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    move_q, move_d;
    logic [4:0]    x_q, x_d, y_q, y_d;
    logic          moved_q, moved_d, blocked_q, blocked_d;

`ifdef PLAYER_REPEAT_EN
    localparam int unsigned RPT_GAP =
        (REPEAT_TICKS > COOLDOWN_TICKS) ? REPEAT_TICKS - COOLDOWN_TICKS : 1;
    localparam logic [CW-1:0] RPT_LD = CW'(RPT_GAP - 1);

    // Set when cooldown expired with a button still held; the IDLE wait
    // before re-issuing runs on the shared counter.
    logic rpt_q, rpt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rpt_q <= 1'b0;
        else       rpt_q <= rpt_d;
    end
`else
    logic unused_lvl;
    assign unused_lvl = ^btn_lvl;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        move_d    = move_q;
        x_d       = x_q;
        y_d       = y_q;
        moved_d   = 1'b0;
        blocked_d = 1'b0;
`ifdef PLAYER_REPEAT_EN
        rpt_d     = rpt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                move_d = MOVE_NONE;
                if (|btn_rise) begin
                    move_d  = btn_to_move(btn_rise);
                    cnt_d   = SETTLE_LD;
                    state_d = ST_SETTLE;
`ifdef PLAYER_REPEAT_EN
                    rpt_d   = 1'b0;
                end else if (rpt_q) begin
                    if (~|btn_lvl) begin
                        rpt_d = 1'b0;
                    end else if (cnt_q == '0) begin
                        move_d  = btn_to_move(btn_lvl);
                        cnt_d   = SETTLE_LD;
                        state_d = ST_SETTLE;
                        rpt_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
`endif
                end
            end
            // LATCH also shows the code, so leaving SETTLE one count early
            // gives the collision stage SETTLE_CYCLES cycles of a stable code.
            ST_SETTLE: begin
                if (cnt_q <= ONE) state_d = ST_LATCH;
                else              cnt_d   = cnt_q - ONE;
            end
            ST_LATCH: begin
                x_d       = new_x_in;
                y_d       = new_y_in;
                moved_d   = (new_x_in != x_q) || (new_y_in != y_q);
                blocked_d = ~moved_d;
                move_d    = MOVE_NONE;
                cnt_d     = COOL_LD;
                state_d   = ST_COOLDOWN;
            end
            ST_COOLDOWN: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
`ifdef PLAYER_REPEAT_EN
                    if (|btn_lvl) begin
                        rpt_d = 1'b1;
                        cnt_d = RPT_LD;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // New map overrides everything, including a LATCH in progress.
        if (map_load) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            move_d    = MOVE_NONE;
            x_d       = START_X;
            y_d       = START_Y;
            moved_d   = 1'b0;
            blocked_d = 1'b0;
`ifdef PLAYER_REPEAT_EN
            rpt_d     = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            move_q    <= MOVE_NONE;
            x_q       <= START_X;
            y_q       <= START_Y;
            moved_q   <= 1'b0;
            blocked_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            move_q    <= move_d;
            x_q       <= x_d;
            y_q       <= y_d;
            moved_q   <= moved_d;
            blocked_q <= blocked_d;
        end
    end

    assign move_out = move_q;
    assign cur_x    = x_q;
    assign cur_y    = y_q;
    assign moved    = moved_q;
    assign blocked  = blocked_q;
    assign busy     = (state_q != ST_IDLE);

endmodule
